bounce_renderer: RTL and testbench
==================================

Name: bounce_renderer

Overview:
Pixel-colour stage directly downstream of the VGA timing generator. It consumes the timing generator's sync, active, coordinate and animation-tick outputs. Once per frame it moves a square box that bounces off the screen edges, and it renders the box, a screen border and the background into an 8-bit RRRGGGBB pixel. Sync is delayed to match the one-tick render latency, so the outputs drive the DAC/connector pins directly.

Parameters:
H_RES, 640, active width in pixels
V_RES, 480, active height in lines
BOX_SIZE, 32, box edge length in pixels; legal range SPEED < BOX_SIZE < V_RES
SPEED, 2, pixels moved per axis per animation tick; must be >= 1
INIT_X, 100, box left edge after reset
INIT_Y, 60, box top edge after reset

Ports:
in_clock  input  1  system clock
in_reset_n  input  1  synchronous, active-low reset
in_strobe  input  1  pixel-tick enable; all state advances only when high
in_hsync  input  1  horizontal sync from timing stage, active-low
in_vsync  input  1  vertical sync from timing stage, active-low
in_active  input  1  visible-area flag
in_anim  input  1  end-of-visible-frame tick
in_x  input  10  active-area x coordinate
in_y  input  9  active-area y coordinate
in_pause  input  1  freezes motion when high; rendering continues
out_hsync  output  1  in_hsync delayed one strobe tick
out_vsync  output  1  in_vsync delayed one strobe tick
out_rgb  output  8  pixel colour, RRRGGGBB
out_bounces  output  8  wall-hit event counter, wraps at 255

Behaviour:
- One clock. Reset is synchronous and active-low: sampled on the in_clock rising edge when in_reset_n=0, and it overrides in_strobe.
- Reset values: out_hsync=1, out_vsync=1, out_rgb=8'h00, out_bounces=0, box_x=INIT_X, box_y=INIT_Y, dir_x=right, dir_y=down, pal_idx=0.
- All registers hold when in_strobe=0.
- Motion update happens only when in_strobe & in_anim & ~in_pause. This is exactly one update per frame, and in_anim held high over non-strobe clocks must not cause multiple updates.
- X axis, moving right: if box_x+BOX_SIZE+SPEED >= H_RES, then box_x <= H_RES-BOX_SIZE, dir_x <= left, and a hit is flagged. Otherwise box_x <= box_x+SPEED.
- X axis, moving left: if box_x <= SPEED, then box_x <= 0, dir_x <= right, and a hit is flagged. Otherwise box_x <= box_x-SPEED.
- Y axis: identical to X, using box_y, V_RES and dir_y (down/up).
- Comparisons are done in 11 bits (x) and 10 bits (y), so no overflow is possible.
- Hit event: if the X axis, the Y axis, or both flag a hit on the same update, pal_idx increments by exactly 1 (2-bit wrap) and out_bounces increments by exactly 1. A corner counts as one event.
- Palette by pal_idx: 0=8'hE0 red, 1=8'h1C green, 2=8'h03 blue, 3=8'hFC yellow.
- Render is registered on in_strobe. Latency is 1 strobe tick from in_x/in_y/in_active to out_rgb.
  - in_active=0: out_rgb=8'h00.
  - Else, inside box (box_x <= in_x < box_x+BOX_SIZE and box_y <= in_y < box_y+BOX_SIZE): out_rgb = palette[pal_idx].
  - Else, border (in_x==0, in_x==H_RES-1, in_y==0 or in_y==V_RES-1): 8'hFF.
  - Else: 8'h00.
  - Priority order: box > border > background.
- Render uses the box state as it stands before the same-tick update. The update occurs at end of the visible area, so there is no tearing.
- out_hsync/out_vsync are registered copies of in_hsync/in_vsync, captured on in_strobe, so they stay aligned with out_rgb.
- Reset mid-frame: all state returns to reset values on that clock; rendering resumes on the next strobe with the initial box position.
- in_pause asserted: position, direction, pal_idx and out_bounces all freeze; the render pipeline still runs.

Test Plan:
- Reset, then one full frame with defaults -> out_rgb=8'hE0 exactly for x 100..131, y 60..91; 8'hFF on the four edge rows/columns; 8'h00 elsewhere and whenever in_active=0; out_bounces=0.
- Latency: drive in_x=100, in_y=60, in_active=1 for one strobe -> out_rgb=8'hE0 on the following strobe. Toggle in_hsync -> out_hsync follows one strobe later.
- Right wall: preload box_x=604, dir right, then 3 anim ticks -> box_x 606, 608 (hit, dir left, pal_idx=1, out_bounces=1), then 606.
- Corner: box_x=606 right, box_y=446 down, one anim tick -> box_x=608, box_y=448, both directions flip, out_bounces increments by 1 only, colour becomes green 8'h1C.
- Gating: hold in_anim=1 for 10 clocks with a single strobe pulse -> exactly one move. in_pause=1 across 5 anim ticks -> no position or counter change.
- Reset mid-frame at x=300, y=200 with box moved -> next clock shows box at 100,60, pal_idx=0, out_rgb=0, syncs=1.

Source files
------------

// File: rtl/bounce_renderer.sv
// bounce_renderer
// Pixel-colour stage that sits right after the VGA timing generator. Once per
// frame it moves a square box that bounces off the screen edges, and on every
// pixel tick it renders the box, a one-pixel screen border and the background
// into an RRRGGGBB pixel. Sync is delayed by the same one-tick render latency,
// so all outputs can drive the connector pins directly.
//
// Ports:
//   in_clock     system clock
//   in_reset_n   synchronous active-low reset (overrides in_strobe)
//   in_strobe    pixel-tick enable, all state advances only when high
//   in_hsync     horizontal sync from the timing stage (active-low)
//   in_vsync     vertical sync from the timing stage (active-low)
//   in_active    visible-area flag
//   in_anim      end-of-visible-frame tick, one motion step per frame
//   in_x, in_y   active-area pixel coordinate
//   in_pause     freezes motion, rendering continues
//   out_hsync    in_hsync delayed one strobe tick
//   out_vsync    in_vsync delayed one strobe tick
//   out_rgb      pixel colour, RRRGGGBB
//   out_bounces  wall-hit event counter, wraps at 255
module bounce_renderer #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int BOX_SIZE = 32,
  parameter int SPEED    = 2,
  parameter int INIT_X   = 100,
  parameter int INIT_Y   = 60
) (
  input  logic       in_clock,
  input  logic       in_reset_n,
  input  logic       in_strobe,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic       in_active,
  input  logic       in_anim,
  input  logic [9:0] in_x,
  input  logic [8:0] in_y,
  input  logic       in_pause,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic [7:0] out_rgb,
  output logic [7:0] out_bounces
);

  // One extra bit on each axis so edge sums can never overflow.
  localparam logic [10:0] X_RES   = 11'(H_RES);
  localparam logic [10:0] X_BOX   = 11'(BOX_SIZE);
  localparam logic [10:0] X_SPEED = 11'(SPEED);
  localparam logic [10:0] X_MAX   = 11'(H_RES - BOX_SIZE);
  localparam logic [10:0] X_LAST  = 11'(H_RES - 1);
  localparam logic [9:0]  Y_RES   = 10'(V_RES);
  localparam logic [9:0]  Y_BOX   = 10'(BOX_SIZE);
  localparam logic [9:0]  Y_SPEED = 10'(SPEED);
  localparam logic [9:0]  Y_MAX   = 10'(V_RES - BOX_SIZE);
  localparam logic [9:0]  Y_LAST  = 10'(V_RES - 1);

  logic [9:0] box_x_q, box_x_d;
  logic [8:0] box_y_q, box_y_d;
  logic       dir_x_q, dir_x_d;   // 1 = moving right
  logic       dir_y_q, dir_y_d;   // 1 = moving down
  logic [1:0] pal_idx_q, pal_idx_d;
  logic [7:0] bounces_q, bounces_d;
  logic [7:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  logic        move_en;
  logic        hit_x, hit_y;
  logic [10:0] bx, px;
  logic [9:0]  by, py;
  logic        in_box, on_border;
  logic [7:0]  box_colour;

  assign bx = {1'b0, box_x_q};
  assign by = {1'b0, box_y_q};
  assign px = {1'b0, in_x};
  assign py = {1'b0, in_y};

  // Gating on in_strobe makes a long in_anim pulse count as one step only.
  assign move_en = in_strobe & in_anim & ~in_pause;

  // Motion: each axis clamps to the wall and reverses when the next step
  // would reach or cross it.
  always_comb begin
    box_x_d   = box_x_q;
    box_y_d   = box_y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    pal_idx_d = pal_idx_q;
    bounces_d = bounces_q;
    hit_x     = 1'b0;
    hit_y     = 1'b0;
    if (move_en) begin
      if (dir_x_q) begin
        if (bx + X_BOX + X_SPEED >= X_RES) begin
          box_x_d = X_MAX[9:0];
          dir_x_d = 1'b0;
          hit_x   = 1'b1;
        end else begin
          box_x_d = box_x_q + X_SPEED[9:0];
        end
      end else begin
        if (bx <= X_SPEED) begin
          box_x_d = '0;
          dir_x_d = 1'b1;
          hit_x   = 1'b1;
        end else begin
          box_x_d = box_x_q - X_SPEED[9:0];
        end
      end
      if (dir_y_q) begin
        if (by + Y_BOX + Y_SPEED >= Y_RES) begin
          box_y_d = Y_MAX[8:0];
          dir_y_d = 1'b0;
          hit_y   = 1'b1;
        end else begin
          box_y_d = box_y_q + Y_SPEED[8:0];
        end
      end else begin
        if (by <= Y_SPEED) begin
          box_y_d = '0;
          dir_y_d = 1'b1;
          hit_y   = 1'b1;
        end else begin
          box_y_d = box_y_q - Y_SPEED[8:0];
        end
      end
      // A corner hit is still a single event.
      if (hit_x || hit_y) begin
        pal_idx_d = pal_idx_q + 2'd1;
        bounces_d = bounces_q + 8'd1;
      end
    end
  end

  // Render from the pre-update box state; priority is box, border, background.
  always_comb begin
    in_box    = (px >= bx) && (px < bx + X_BOX) && (py >= by) && (py < by + Y_BOX);
    on_border = (px == 11'd0) || (px == X_LAST) || (py == 10'd0) || (py == Y_LAST);
    case (pal_idx_q)
      2'd0:    box_colour = 8'hE0;
      2'd1:    box_colour = 8'h1C;
      2'd2:    box_colour = 8'h03;
      default: box_colour = 8'hFC;
    endcase
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (in_strobe) begin
      hsync_d = in_hsync;
      vsync_d = in_vsync;
      if (!in_active)     rgb_d = 8'h00;
      else if (in_box)    rgb_d = box_colour;
      else if (on_border) rgb_d = 8'hFF;
      else                rgb_d = 8'h00;
    end
  end

  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      box_x_q   <= 10'(INIT_X);
      box_y_q   <= 9'(INIT_Y);
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      pal_idx_q <= 2'd0;
      bounces_q <= 8'd0;
      rgb_q     <= 8'h00;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
    end else begin
      box_x_q   <= box_x_d;
      box_y_q   <= box_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      pal_idx_q <= pal_idx_d;
      bounces_q <= bounces_d;
      rgb_q     <= rgb_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign out_hsync   = hsync_q;
  assign out_vsync   = vsync_q;
  assign out_rgb     = rgb_q;
  assign out_bounces = bounces_q;

endmodule

// File: tb/tb_bounce_renderer.sv
// tb_bounce_renderer
// Directed bench for bounce_renderer. Two instances share all inputs: "dut"
// uses the default start position, "dut_c" starts at (604,444) so that it
// reaches the bottom-right corner on its second motion step.
module tb_bounce_renderer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       strobe;
  logic       hsync, vsync, active, anim, pause;
  logic [9:0] x;
  logic [8:0] y;

  logic       out_hsync, out_vsync;
  logic [7:0] out_rgb, out_bounces;
  logic       c_hsync, c_vsync;
  logic [7:0] c_rgb, c_bounces;

  int checks = 0;
  int errors = 0;

  // 100 MHz-style free-running clock.
  always #5 clock = ~clock;

  bounce_renderer dut (
    .in_clock(clock), .in_reset_n(reset_n), .in_strobe(strobe),
    .in_hsync(hsync), .in_vsync(vsync), .in_active(active), .in_anim(anim),
    .in_x(x), .in_y(y), .in_pause(pause),
    .out_hsync(out_hsync), .out_vsync(out_vsync),
    .out_rgb(out_rgb), .out_bounces(out_bounces)
  );

  bounce_renderer #(.INIT_X(604), .INIT_Y(444)) dut_c (
    .in_clock(clock), .in_reset_n(reset_n), .in_strobe(strobe),
    .in_hsync(hsync), .in_vsync(vsync), .in_active(active), .in_anim(anim),
    .in_x(x), .in_y(y), .in_pause(pause),
    .out_hsync(c_hsync), .out_vsync(c_vsync),
    .out_rgb(c_rgb), .out_bounces(c_bounces)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one clock with strobe high, then sample just after the edge.
  task automatic applyStimulus(input logic [9:0] px, input logic [8:0] py,
                               input logic act, input logic hs,
                               input logic vs, input logic an);
    @(negedge clock);
    strobe = 1'b1;
    x = px; y = py; active = act; hsync = hs; vsync = vs; anim = an;
    @(posedge clock);
    #1;
    strobe = 1'b0;
    anim   = 1'b0;
  endtask

  // Render one visible pixel with syncs idle.
  task automatic probe(input logic [9:0] px, input logic [8:0] py);
    applyStimulus(px, py, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  // One motion step (animation tick during blanking).
  task automatic animTick();
    applyStimulus(10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  logic [7:0] exp_rgb;

  initial begin
    reset_n = 1'b0; strobe = 1'b0; hsync = 1'b1; vsync = 1'b1;
    active = 1'b0; anim = 1'b0; pause = 1'b0; x = '0; y = '0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_rgb", out_rgb, 8'h00);
    checkOutput("reset_hsync", out_hsync, 1'b1);
    checkOutput("reset_vsync", out_vsync, 1'b1);
    checkOutput("reset_bounces", out_bounces, 8'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Spot pixels of the first frame: box corners, edges and border.
    probe(10'd100, 9'd60);  checkOutput("box_tl", out_rgb, 8'hE0);
    probe(10'd131, 9'd91);  checkOutput("box_br", out_rgb, 8'hE0);
    probe(10'd99, 9'd60);   checkOutput("left_of_box", out_rgb, 8'h00);
    probe(10'd132, 9'd60);  checkOutput("right_of_box", out_rgb, 8'h00);
    probe(10'd100, 9'd59);  checkOutput("above_box", out_rgb, 8'h00);
    probe(10'd100, 9'd92);  checkOutput("below_box", out_rgb, 8'h00);
    probe(10'd0, 9'd200);   checkOutput("border_left", out_rgb, 8'hFF);
    probe(10'd639, 9'd200); checkOutput("border_right", out_rgb, 8'hFF);
    probe(10'd300, 9'd0);   checkOutput("border_top", out_rgb, 8'hFF);
    probe(10'd300, 9'd479); checkOutput("border_bottom", out_rgb, 8'hFF);
    probe(10'd300, 9'd200); checkOutput("background", out_rgb, 8'h00);
    applyStimulus(10'd100, 9'd60, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("inactive_in_box", out_rgb, 8'h00);
    applyStimulus(10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("inactive_border", out_rgb, 8'h00);

    // Full scan of one row through the box.
    for (int i = 0; i < 640; i++) begin
      probe(10'(i), 9'd75);
      if (i == 0 || i == 639)      exp_rgb = 8'hFF;
      else if (i >= 100 && i <= 131) exp_rgb = 8'hE0;
      else                         exp_rgb = 8'h00;
      checkOutput($sformatf("row75_x%0d", i), out_rgb, exp_rgb);
    end
    checkOutput("frame_bounces", out_bounces, 8'd0);

    // Latency and sync delay; without strobe everything must hold.
    applyStimulus(10'd100, 9'd60, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("lat_rgb", out_rgb, 8'hE0);
    checkOutput("lat_hsync_low", out_hsync, 1'b0);
    @(negedge clock);
    hsync = 1'b1; vsync = 1'b0; active = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("hold_hsync", out_hsync, 1'b0);
    checkOutput("hold_vsync", out_vsync, 1'b1);
    checkOutput("hold_rgb", out_rgb, 8'hE0);
    applyStimulus(10'd100, 9'd60, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lat_hsync_high", out_hsync, 1'b1);
    checkOutput("lat_vsync_low", out_vsync, 1'b0);
    checkOutput("lat_rgb_blank", out_rgb, 8'h00);

    // in_anim held for 10 clocks with a single strobe: exactly one step.
    @(negedge clock);
    anim = 1'b1; active = 1'b0; vsync = 1'b1;
    strobe = 1'b1;
    @(negedge clock);
    strobe = 1'b0;
    repeat (9) @(negedge clock);
    anim = 1'b0;
    probe(10'd102, 9'd62);  checkOutput("gate_moved", out_rgb, 8'hE0);
    probe(10'd101, 9'd62);  checkOutput("gate_left_edge", out_rgb, 8'h00);
    probe(10'd102, 9'd61);  checkOutput("gate_top_edge", out_rgb, 8'h00);
    probe(10'd133, 9'd93);  checkOutput("gate_br", out_rgb, 8'hE0);
    probe(10'd134, 9'd93);  checkOutput("gate_one_step", out_rgb, 8'h00);
    probe(10'd606, 9'd446); checkOutput("c_tick1", c_rgb, 8'hE0);
    probe(10'd605, 9'd446); checkOutput("c_tick1_left", c_rgb, 8'h00);

    // Pause across 5 animation ticks: nothing moves or counts.
    pause = 1'b1;
    repeat (5) animTick();
    pause = 1'b0;
    probe(10'd102, 9'd62);  checkOutput("pause_pos", out_rgb, 8'hE0);
    probe(10'd101, 9'd62);  checkOutput("pause_left", out_rgb, 8'h00);
    probe(10'd606, 9'd446); checkOutput("pause_c_pos", c_rgb, 8'hE0);
    probe(10'd605, 9'd446); checkOutput("pause_c_left", c_rgb, 8'h00);
    checkOutput("pause_bounces", out_bounces, 8'd0);
    checkOutput("pause_c_bounces", c_bounces, 8'd0);

    // Corner: both axes hit on the same step, one event, colour green.
    animTick();
    probe(10'd608, 9'd448); checkOutput("corner_pos", c_rgb, 8'h1C);
    probe(10'd607, 9'd448); checkOutput("corner_left", c_rgb, 8'h00);
    probe(10'd608, 9'd447); checkOutput("corner_top", c_rgb, 8'h00);
    probe(10'd639, 9'd479); checkOutput("corner_box_over_border", c_rgb, 8'h1C);
    checkOutput("corner_bounces", c_bounces, 8'd1);

    // Both directions reversed: back to 606,446 with no new event.
    animTick();
    probe(10'd606, 9'd446); checkOutput("rebound_pos", c_rgb, 8'h1C);
    probe(10'd638, 9'd446); checkOutput("rebound_right", c_rgb, 8'h00);
    probe(10'd606, 9'd445); checkOutput("rebound_top", c_rgb, 8'h00);
    checkOutput("rebound_bounces", c_bounces, 8'd1);

    // Run to the left wall: top wall hit on step 226, left wall on 306.
    for (int t = 4; t <= 305; t++) animTick();
    probe(10'd2, 9'd158);  checkOutput("near_left_pos", c_rgb, 8'h03);
    probe(10'd1, 9'd158);  checkOutput("near_left_gap", c_rgb, 8'h00);
    probe(10'd33, 9'd189); checkOutput("near_left_br", c_rgb, 8'h03);
    probe(10'd34, 9'd158); checkOutput("near_left_right", c_rgb, 8'h00);
    checkOutput("near_left_bounces", c_bounces, 8'd2);
    animTick();
    probe(10'd0, 9'd160);  checkOutput("left_wall_pos", c_rgb, 8'hFC);
    probe(10'd0, 9'd159);  checkOutput("left_wall_border", c_rgb, 8'hFF);
    probe(10'd32, 9'd160); checkOutput("left_wall_right", c_rgb, 8'h00);
    probe(10'd31, 9'd191); checkOutput("left_wall_br", c_rgb, 8'hFC);
    checkOutput("left_wall_bounces", c_bounces, 8'd3);

    // Mid-frame reset with strobe high: reset wins and restores everything.
    @(negedge clock);
    reset_n = 1'b0; strobe = 1'b1;
    x = 10'd300; y = 9'd200; active = 1'b1; hsync = 1'b0; vsync = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("midreset_rgb", out_rgb, 8'h00);
    checkOutput("midreset_hsync", out_hsync, 1'b1);
    checkOutput("midreset_vsync", out_vsync, 1'b1);
    checkOutput("midreset_c_bounces", c_bounces, 8'd0);
    checkOutput("midreset_bounces", out_bounces, 8'd0);
    @(negedge clock);
    strobe = 1'b0; reset_n = 1'b1; hsync = 1'b1; vsync = 1'b1;
    probe(10'd100, 9'd60);  checkOutput("after_reset_pos", out_rgb, 8'hE0);
    probe(10'd99, 9'd60);   checkOutput("after_reset_left", out_rgb, 8'h00);
    probe(10'd604, 9'd444); checkOutput("after_reset_c_pal", c_rgb, 8'hE0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
